// File: rtl/seq_tx_pkg.sv
// seq_tx_pkg: shared states, preamble constants and counter sizing for seq_frame_tx.
package seq_tx_pkg;

   typedef enum logic [2:0] {IDLE, PRE, DATA, PAR, GAP} state_t;

   localparam logic [2:0] PREAMBLE     = 3'b001;
   localparam int         PREAMBLE_LEN = 3;
   localparam logic       IDLE_LEVEL   = 1'b0;

   function automatic int cnt_width(input int width, input int gap);
      int m;
      m = width > gap ? width : gap;
      m = m > PREAMBLE_LEN ? m : PREAMBLE_LEN;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/seq_tx_shifter.sv
// seq_tx_shifter: payload load/shift-left register with MSB tap and parity captured at load.
module seq_tx_shifter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] data,
   output logic             msb,
   output logic             parity
);

   logic [WIDTH-1:0] sr;
   logic             par;

   // parity is latched at load so shifting does not disturb it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sr  <= '0;
         par <= 1'b0;
      end else if (load) begin
         sr  <= data;
         par <= ^data;
      end else if (shift) begin
         sr  <= sr << 1;
      end
   end

   assign msb    = sr[WIDTH-1];
   assign parity = par;

endmodule

// File: rtl/seq_frame_tx.sv
// seq_frame_tx: serial frame transmitter (001 preamble, payload MSB-first, optional parity, idle gap).
// Define SEQ_TX_PARITY_EN to include the even-parity bit after the payload.
module seq_frame_tx
   import seq_tx_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int GAP   = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             out_seq,
   output logic             out_active,
   output logic             tx_done
);

   localparam int             CW        = cnt_width(WIDTH, GAP);
   localparam logic [CW-1:0]  GAP_LOAD  = CW'(GAP == 0 ? 0 : GAP - 1);
   localparam state_t         AFTER     = GAP == 0 ? IDLE : seq_tx_pkg::GAP;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          accept, last, msb, par_bit;
   logic [3:0]    pre_ext;

   assign accept  = in_valid && in_ready;
   assign last    = cnt == '0;
   assign pre_ext = {1'b0, PREAMBLE};

   seq_tx_shifter #(.WIDTH(WIDTH)) u_shifter (
      .clk    (clk),
      .reset  (reset),
      .load   (accept),
      .shift  (state == DATA),
      .data   (in_data),
      .msb    (msb),
      .parity (par_bit)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   // counter counts down to zero in each state and reloads on every state entry
   always_comb begin
      state_n = state;
      cnt_n   = last ? cnt : cnt - 1'b1;
      case (state)
         IDLE: if (accept) begin
            state_n = PRE;
            cnt_n   = CW'(PREAMBLE_LEN - 1);
         end
         PRE: if (last) begin
            state_n = DATA;
            cnt_n   = CW'(WIDTH - 1);
         end
         DATA: if (last) begin
`ifdef SEQ_TX_PARITY_EN
            state_n = PAR;
            cnt_n   = '0;
`else
            state_n = AFTER;
            cnt_n   = GAP_LOAD;
`endif
         end
         PAR: begin
            state_n = AFTER;
            cnt_n   = GAP_LOAD;
         end
         seq_tx_pkg::GAP: if (last) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   assign in_ready   = state == IDLE;
   assign out_active = state == PRE || state == DATA || state == PAR;
   assign out_seq    = state == PRE  ? pre_ext[cnt[1:0]] :
                       state == DATA ? msb :
                       state == PAR  ? par_bit : IDLE_LEVEL;
`ifdef SEQ_TX_PARITY_EN
   assign tx_done    = state == PAR;
`else
   assign tx_done    = state == DATA && last;
`endif

endmodule

// File: tb/tb_seq_frame_tx.sv
// tb_seq_frame_tx: directed self-checking bench for seq_frame_tx (WIDTH=8, GAP=2 and a GAP=0 instance).
module tb_seq_frame_tx;

   localparam int W = 8;
   localparam int G = 2;
`ifdef SEQ_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int L = 3 + W + P;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [W-1:0] in_data = '0;
   logic         in_valid = 1'b0;
   logic         in_ready, out_seq, out_active, tx_done;
   logic         valid0 = 1'b0;
   logic         ready0, seq0, active0, done0;
   int           checks = 0;
   int           errors = 0;

   always #5 clk = ~clk;

   seq_frame_tx #(.WIDTH(W), .GAP(G)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .out_seq(out_seq), .out_active(out_active), .tx_done(tx_done)
   );

   seq_frame_tx #(.WIDTH(W), .GAP(0)) dut_g0 (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(valid0),
      .in_ready(ready0), .out_seq(seq0), .out_active(active0), .tx_done(done0)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic exp_bit(input logic [W-1:0] d, input int i);
      if (i < 3) return i == 2;
      if (i < 3 + W) return d[W-1-(i-3)];
      return ^d;
   endfunction

   // leaves in_valid high; caller drops it unless chaining frames
   task automatic accept(input logic [W-1:0] d);
      int n;
      in_data  = d;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) check("accept_timeout", 0, 1);
      tick();
   endtask

   // entered in cycle k+1; returns in cycle k+1+L+GAP
   task automatic frame_check(input logic [W-1:0] d, input string tag);
      for (int i = 0; i < L; i++) begin
         check({tag, "_seq"}, out_seq, exp_bit(d, i));
         check({tag, "_active"}, out_active, 1);
         check({tag, "_done"}, tx_done, i == L - 1);
         check({tag, "_ready_busy"}, in_ready, 0);
         tick();
      end
      for (int g = 0; g < G; g++) begin
         check({tag, "_gap_seq"}, out_seq, 0);
         check({tag, "_gap_active"}, out_active, 0);
         check({tag, "_gap_ready"}, in_ready, 0);
         tick();
      end
      check({tag, "_ready_back"}, in_ready, 1);
   endtask

   initial begin
      repeat (3) tick();
      check("rst_ready", in_ready, 1);
      check("rst_seq", out_seq, 0);
      check("rst_active", out_active, 0);
      check("rst_done", tx_done, 0);
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("idle_ready", in_ready, 1);
         check("idle_seq", out_seq, 0);
         check("idle_active", out_active, 0);
         check("idle_done", tx_done, 0);
      end

      accept(8'hA5);
      in_valid = 1'b0;
      frame_check(8'hA5, "a5");
      tick();

      accept(8'h07);
      in_valid = 1'b0;
      frame_check(8'h07, "x07");

      accept(8'hFF);
      in_data = 8'h00;
      frame_check(8'hFF, "b2b_ff");
      accept(8'h00);
      in_valid = 1'b0;
      frame_check(8'h00, "b2b_00");
      tick();
      check("b2b_no_dup", in_ready, 1);

      accept(8'hA5);
      in_valid = 1'b0;
      repeat (5) tick();
      check("pre_rst_bit5", out_seq, 1);
      reset = 1'b1;
      #1;
      check("mid_rst_seq", out_seq, 0);
      check("mid_rst_active", out_active, 0);
      check("mid_rst_ready", in_ready, 1);
      check("mid_rst_done", tx_done, 0);
      tick();
      check("mid_rst_hold_done", tx_done, 0);
      reset = 1'b0;
      accept(8'h3C);
      in_valid = 1'b0;
      frame_check(8'h3C, "after_rst");
      tick();

      in_data = 8'h5A;
      valid0  = 1'b1;
      tick();
      valid0 = 1'b0;
      for (int i = 0; i < L; i++) begin
         check("g0_seq", seq0, exp_bit(8'h5A, i));
         check("g0_active", active0, 1);
         check("g0_done", done0, i == L - 1);
         check("g0_ready_busy", ready0, 0);
         tick();
      end
      check("g0_ready_back", ready0, 1);
      check("g0_active_off", active0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_frame_tx.md
# seq_frame_tx

Serial frame transmitter that drives the single-bit sequence line read by the team's Mealy sequence detectors. It accepts a parallel payload word over a valid/ready handshake and emits one bit per clock: a fixed `001` preamble, the payload MSB-first, an optional even-parity bit, then a configurable idle gap. It sits upstream of the detector as the bit-stream source for link bring-up and pattern testing.

## Interface
- `WIDTH`, default 8: payload bits per frame; must be ≥1.
- `GAP`, default 2: idle cycles after each frame; must be ≥0.
- `clk` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-high; forces the idle state immediately.
- `in_data` input WIDTH: payload word; sampled on the accept edge.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: block can accept a word. Reset value 1.
- `out_seq` output 1: serial bit line. Reset and idle value 0.
- `out_active` output 1: `out_seq` carries a frame bit this cycle. Reset value 0.
- `tx_done` output 1: one-cycle pulse with the last frame bit. Reset value 0.

## Operation
- Accept occurs on a rising edge where `in_valid && in_ready`. `in_data` is captured into the shift register and even parity is computed.
- `in_ready` is 1 only in IDLE. In all other states it is 0, and `in_valid` is ignored.
- Holding `in_valid` high with no accept has no effect. The source must hold `in_data` stable until the accept edge.
- FSM states and transitions:
  - IDLE → PRE on accept.
  - PRE drives 0, 0, 1 over 3 cycles, then → DATA.
  - DATA drives `in_data[WIDTH-1]` down to `in_data[0]`, then → PAR, or → GAP if parity is compiled out.
  - PAR drives 1 cycle of parity, then → GAP.
  - GAP holds `out_seq`=0 and `out_active`=0 for `GAP` cycles, then → IDLE. With `GAP`=0, the FSM goes straight to IDLE.
- Parity bit = XOR-reduce of the captured payload, so the total count of 1s in the payload plus the parity bit is even.
- `out_seq` and `out_active` are registered and driven directly from state and shift-register flops; there is no combinational path from inputs.
- Counter width is `$clog2(max(WIDTH, GAP, 3) + 1)`. The counter reloads on every state entry, and wrap-around is never reached.
- If `reset` asserts mid-frame, all outputs return to reset values asynchronously and the frame is dropped. The first accept is possible on the first rising edge after `reset` deasserts.
- There is no back-pressure from downstream; the line is always consumed.

## Timing
- Accept at edge k. The preamble occupies cycles k+1..k+3, and payload bit i occupies cycle k+4+(WIDTH-1-i).
- Parity occupies cycle k+4+WIDTH.
- `tx_done` is high in the cycle of the last frame bit: k+4+WIDTH with parity, k+3+WIDTH without.
- Frame length is L = 3+WIDTH+1 with parity, or 3+WIDTH without.
- `in_ready` returns to 1 at cycle k+1+L+GAP.
- Maximum throughput is one frame per L+GAP+1 cycles. The single IDLE cycle between frames is mandatory.

## Configuration
- `SEQ_TX_PARITY_EN` defined: PAR state is present, L = WIDTH+4, and `tx_done` falls on the parity bit.
- `SEQ_TX_PARITY_EN` undefined: PAR state and parity logic are removed, L = WIDTH+3, and `tx_done` falls on payload bit 0.

## Structure
- Shared package `seq_tx_pkg`:
  - state enum `IDLE`/`PRE`/`DATA`/`PAR`/`GAP`
  - `PREAMBLE` = 3'b001
  - `PREAMBLE_LEN` = 3
  - idle line level constant 1'b0
- Sub-module `seq_tx_shifter`: WIDTH-bit load/shift-left register exposing the MSB and XOR-reduced parity. The FSM and counters stay in the top level.

## Test plan
- Reset then idle: assert `reset` for 3 cycles, then release with `in_valid`=0 → `in_ready`=1, `out_seq`=0, `out_active`=0 and `tx_done`=0 held for 20 cycles.
- Single frame, WIDTH=8, GAP=2, parity on, `in_data`=8'hA5:
  - `out_seq` = 0,0,1, 1,0,1,0,0,1,0,1, 0 on cycles k+1..k+12
  - `out_active` = 1 throughout those cycles
  - `tx_done` = 1 at k+12
  - `in_ready` = 1 at k+15
- Parity check, `in_data`=8'h07 → parity bit = 1 at k+12. Parity off, `in_data`=8'hA5 → 11-bit frame, with `tx_done` at k+11.
- Back-to-back: hold `in_valid`=1 with words 8'hFF then 8'h00 → the second accept lands exactly one cycle after GAP ends, and no word is lost or duplicated.
- Reset mid-frame: assert `reset` during payload bit 5 → `out_seq`=0, `out_active`=0 and `in_ready`=1 immediately, with no `tx_done` pulse. The next frame transmits correctly.
- GAP=0 build → `in_ready`=1 in the cycle right after `tx_done`.
